// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel arbiter: FSM encoding,
// descriptor field widths and the default address window limit.
package dma_pkg;

  localparam int          SIZE_W        = 16;
  localparam int          ADDR_W        = 32;
  localparam logic [31:0] RAM_LIMIT_DEF = 32'h0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from ptr+1, wrapping to channel 0.
module dma_rr_picker #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_oh_o,
  output logic [IW-1:0]  gnt_idx_o,
  output logic           any_o
);

  int          c;
  logic [IW-1:0] cidx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    c         = 0;
    cidx      = '0;
    for (int k = 1; k <= NCH; k++) begin
      c    = (int'(ptr_i) + k) % NCH;
      cidx = IW'(c);
      if (!any_o && req_i[cidx]) begin
        any_o          = 1'b1;
        gnt_oh_o[cidx] = 1'b1;
        gnt_idx_o      = cidx;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter granting one DMA channel at a time to a shared controller.
// Optional DMA_ARB_RANGE_CHECK_EN rejects descriptors that cross RAM_LIMIT.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter logic [31:0] RAM_LIMIT = RAM_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH*SIZE_W-1:0] ch_size,
  input  logic [NCH*ADDR_W-1:0] ch_src,
  input  logic [NCH*ADDR_W-1:0] ch_dst,
  output logic [NCH-1:0]        ch_done,
  output logic [NCH-1:0]        ch_err,
  output logic                  busy,
  output logic [$clog2(NCH)-1:0] grant_id,
  output logic                  dma_start,
  output logic [SIZE_W-1:0]     size_dtrans,
  output logic [ADDR_W-1:0]     src_reg,
  output logic [ADDR_W-1:0]     dst_reg,
  input  logic                  dma_done
);

  localparam int IW = $clog2(NCH);

  state_e                        state_q;
  logic [IW-1:0]                 ptr_q, grant_q;
  logic [NCH-1:0]                gnt_oh_q, done_q;
  logic                          start_q, busy_q;
  logic [SIZE_W-1:0]             size_q;
  logic [ADDR_W-1:0]             src_q, dst_q;

  logic [NCH-1:0][SIZE_W-1:0]    size_a;
  logic [NCH-1:0][ADDR_W-1:0]    src_a, dst_a;
  logic [NCH-1:0]                win_oh;
  logic [IW-1:0]                 win_idx;
  logic                          win_any;
  logic                          range_bad;

  assign size_a = ch_size;
  assign src_a  = ch_src;
  assign dst_a  = ch_dst;

  dma_rr_picker #(.NCH(NCH), .IW(IW)) u_pick (
    .req_i     (ch_req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx),
    .any_o     (win_any)
  );

`ifdef DMA_ARB_RANGE_CHECK_EN
  logic [NCH-1:0] err_q;
  logic [32:0]    src_end, dst_end;
  // 33-bit sums so a wrap past 4 GiB still counts as out of window
  assign src_end   = {1'b0, src_a[win_idx]} + {17'b0, size_a[win_idx]};
  assign dst_end   = {1'b0, dst_a[win_idx]} + {17'b0, size_a[win_idx]};
  assign range_bad = (src_end >= {1'b0, RAM_LIMIT}) || (dst_end >= {1'b0, RAM_LIMIT});
  assign ch_err    = err_q;
`else
  assign range_bad = 1'b0;
  assign ch_err    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IW'(NCH-1);
      grant_q  <= '0;
      gnt_oh_q <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      size_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
`ifdef DMA_ARB_RANGE_CHECK_EN
      err_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (win_any) begin
          grant_q  <= win_idx;
          gnt_oh_q <= win_oh;
          size_q   <= size_a[win_idx];
          src_q    <= src_a[win_idx];
          dst_q    <= dst_a[win_idx];
          busy_q   <= 1'b1;
          if (range_bad) begin
            state_q <= ST_DONE;
            done_q  <= win_oh;
`ifdef DMA_ARB_RANGE_CHECK_EN
            err_q   <= win_oh;
`endif
          end else begin
            state_q <= ST_ISSUE;
            start_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          start_q <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (dma_done) begin
          done_q  <= gnt_oh_q;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= '0;
`ifdef DMA_ARB_RANGE_CHECK_EN
          err_q   <= '0;
`endif
          ptr_q   <= grant_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_done     = done_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign dma_start   = start_q;
  assign size_dtrans = size_q;
  assign src_reg     = src_q;
  assign dst_reg     = dst_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Randomized bench for dma_channel_arbiter against a transaction-level model
// of pending channels, round-robin order and the address window check.
module tb_dma_channel_arbiter;

  localparam int          NCH = 4;
  localparam logic [31:0] LIM = 32'h0001_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   ch_req;
  logic [NCH*16-1:0] ch_size;
  logic [NCH*32-1:0] ch_src, ch_dst;
  logic [NCH-1:0]   ch_done, ch_err;
  logic             busy, dma_start, dma_done;
  logic [1:0]       grant_id;
  logic [15:0]      size_dtrans;
  logic [31:0]      src_reg, dst_reg;

  dma_channel_arbiter #(.NCH(NCH), .RAM_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_size(ch_size),
    .ch_src(ch_src), .ch_dst(ch_dst), .ch_done(ch_done), .ch_err(ch_err),
    .busy(busy), .grant_id(grant_id), .dma_start(dma_start),
    .size_dtrans(size_dtrans), .src_reg(src_reg), .dst_reg(dst_reg),
    .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // model state: which channels are waiting, last served channel, descriptors
  bit          pend [NCH];
  int          ptr_m;
  logic [15:0] sz_m  [NCH];
  logic [31:0] src_m [NCH], dst_m [NCH];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // winner = pending channel at the smallest forward distance past the last grant
  function automatic int pick_m();
    int best = -1, bd = NCH + 1, d;
    for (int c = 0; c < NCH; c++)
      if (pend[c]) begin
        d = (c - ptr_m - 1 + 2 * NCH) % NCH;
        if (d < bd) begin bd = d; best = c; end
      end
    return best;
  endfunction

  function automatic bit bad_m(input int w);
`ifdef DMA_ARB_RANGE_CHECK_EN
    longint lim = longint'(LIM);
    return (longint'(src_m[w]) + longint'(sz_m[w]) >= lim) ||
           (longint'(dst_m[w]) + longint'(sz_m[w]) >= lim);
`else
    return 1'b0;
`endif
  endfunction

  task automatic raise(input int c, input logic [15:0] sz, input logic [31:0] s, input logic [31:0] d);
    pend[c] = 1'b1; sz_m[c] = sz; src_m[c] = s; dst_m[c] = d;
    ch_req[c] = 1'b1;
    ch_size[16*c +: 16] = sz;
    ch_src[32*c +: 32]  = s;
    ch_dst[32*c +: 32]  = d;
  endtask

  task automatic rand_raise();
    int c;
    c = $urandom_range(0, NCH-1);
    if (!pend[c])
      raise(c, 16'($urandom_range(0, 16'h7FFF)), 32'($urandom_range(0, 32'h7FFF)),
            32'($urandom_range(0, 32'h7FFF)));
  endtask

  task automatic clear_all();
    ch_req = '0;
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, 128'(dma_start), 128'(0));
    chk({tag, "_done"},  128'(ch_done), 128'(0));
    chk({tag, "_err"},   128'(ch_err), 128'(0));
    chk({tag, "_busy"},  128'(busy), 128'(0));
    chk({tag, "_gid"},   128'(grant_id), 128'(0));
    chk({tag, "_desc"},  {80'(0), size_dtrans, src_reg, dst_reg}, 128'(0));
  endtask

  // Called at a negedge with the DUT in IDLE and at least one channel pending.
  // raise_ch: -1 none, -2 random, else channel raised in the first WAIT cycle.
  task automatic run_txn(input int dly, input int raise_ch, output int w);
    logic [NCH-1:0] oh;
    w  = pick_m();
    oh = NCH'(1) << w;
    step();
    chk("busy", 128'(busy), 128'(1));
    chk("gid", 128'(grant_id), 128'(w));
    chk("desc", {80'(0), size_dtrans, src_reg, dst_reg}, {80'(0), sz_m[w], src_m[w], dst_m[w]});
    if (bad_m(w)) begin
      chk("rc_start", 128'(dma_start), 128'(0));
      chk("rc_done", 128'(ch_done), 128'(oh));
      chk("rc_err", 128'(ch_err), 128'(oh));
    end else begin
      chk("start", 128'(dma_start), 128'(1));
      step();
      chk("start_pulse", 128'(dma_start), 128'(0));
      if (raise_ch >= 0 && !pend[raise_ch])
        raise(raise_ch, 16'h40, 32'h1000, 32'h2000);
      for (int i = 0; i < dly; i++) begin
        if (raise_ch == -2) rand_raise();
        step();
        chk("wait_done", 128'(ch_done), 128'(0));
        chk("wait_gid", 128'(grant_id), 128'(w));
      end
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      chk("done", 128'(ch_done), 128'(oh));
      chk("err", 128'(ch_err), 128'(0));
    end
    pend[w] = 1'b0; ch_req[w] = 1'b0; ptr_m = w;
    step();
    chk("idle_done", 128'(ch_done), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int w;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; dma_done = 1'b0; ch_req = '0;
    ch_size = '0; ch_src = '0; ch_dst = '0;
    clear_all(); ptr_m = NCH - 1;
    step(); step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // all channels held: strict rotation from channel 0
    for (int c = 0; c < NCH; c++) raise(c, 16'(16 * (c + 1)), 32'(c * 'h100), 32'(c * 'h100 + 'h4000));
    for (int i = 0; i < 5; i++) begin
      run_txn(2, -1, w);
      chk("rr_order", 128'(w), 128'(exp_ord[i]));
      raise(w, 16'h20, 32'h300, 32'h400);
    end
    clear_all();
    step();

    // single channel 2 with a fixed descriptor
    raise(2, 16'h0010, 32'h100, 32'h200);
    run_txn(4, -1, w);

    // channel 0 raised mid-transfer does not preempt channel 1
    raise(1, 16'h8, 32'h10, 32'h20);
    ptr_m = 2;
    run_txn(3, 0, w);
    chk("nopreempt", 128'(w), 128'(1));
    run_txn(1, -1, w);
    chk("next_ch0", 128'(w), 128'(0));

    // descriptor crossing the window
    raise(1, 16'h0020, 32'h0000_FFF0, 32'h300);
    run_txn(0, -1, w);

    // reset during WAIT abandons the transfer
    raise(1, 16'h8, 32'h10, 32'h20);
    step(); step();
    #1 rst_n = 1'b0; clear_all();
    #1 chk_zero("async_rst");
    step();
    rst_n = 1'b1; ptr_m = NCH - 1;
    step();
    chk("post_rst_done", 128'(ch_done), 128'(0));
    raise(3, 16'h4, 32'h50, 32'h60);
    run_txn(1, -1, w);
    chk("post_rst_gid", 128'(w), 128'(3));

    // random traffic
    for (int i = 0; i < 40; i++) begin
      rand_raise();
      if ($urandom_range(0, 1) == 1) rand_raise();
      if (pick_m() < 0) raise(int'($urandom_range(0, NCH-1)), 16'h1, 32'h0, 32'h0);
      run_txn(int'($urandom_range(0, 4)), -2, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
